// File: rtl/io_led_seg_ctrl.sv
// LED register and eight-digit multiplexed seven-segment driver fed by CPU I/O stores.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_EN.
module io_led_seg_ctrl #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        led_ctrl,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    output logic [15:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [3:0] ADDR_LED = 4'h0;
    localparam logic [3:0] ADDR_SEG = 4'h4;

    logic [31:0]      seg_reg;
    logic [DIV_W-1:0] div;
    logic [2:0]       idx;
    logic             wr_led;
    logic             wr_seg;
    logic [3:0]       nibble;
    logic [7:0]       digit_cat;
    logic             unused_addr;

    assign unused_addr = ^io_addr[31:4];

    assign wr_led = led_ctrl && (io_addr[3:0] == ADDR_LED);
    assign wr_seg = led_ctrl && (io_addr[3:0] == ADDR_SEG);

    // Common-anode, active-low segments; dp (bit 7) stays off for every digit.
    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] c;
        case (n)
            4'h0: c = 8'hC0;
            4'h1: c = 8'hF9;
            4'h2: c = 8'hA4;
            4'h3: c = 8'hB0;
            4'h4: c = 8'h99;
            4'h5: c = 8'h92;
            4'h6: c = 8'h82;
            4'h7: c = 8'hF8;
            4'h8: c = 8'h80;
            4'h9: c = 8'h90;
            4'hA: c = 8'h88;
            4'hB: c = 8'h83;
            4'hC: c = 8'hC6;
            4'hD: c = 8'hA1;
            4'hE: c = 8'h86;
            default: c = 8'h8E;
        endcase
        return c;
    endfunction

    always_comb begin
        nibble    = seg_reg[{idx, 2'b00} +: 4];
        digit_cat = hex7(nibble);
`ifdef SEG_BLANK_EN
        // Digit 0 always shows so a zero value still displays "0".
        if ((idx != 3'd0) && ((seg_reg >> {idx, 2'b00}) == 32'd0)) begin
            digit_cat = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led     <= 16'h0000;
            seg_reg <= 32'h0000_0000;
            div     <= '0;
            idx     <= 3'd0;
            seg_an  <= 8'hFE;
            seg_cat <= 8'hC0;
        end else begin
            if (wr_led) begin
                led <= io_wdata[15:0];
            end
            if (wr_seg) begin
                seg_reg <= io_wdata;
            end

            if (div == DIV_LAST) begin
                div <= '0;
                idx <= idx + 3'd1;
            end else begin
                div <= div + 1'b1;
            end

            // Outputs use pre-edge idx/seg_reg, giving one extra cycle of latency.
            seg_an  <= ~(8'd1 << idx);
            seg_cat <= digit_cat;
        end
    end

endmodule

// File: tb/tb_io_led_seg_ctrl.sv
// Randomized self-checking bench for io_led_seg_ctrl against a cycle-count reference model.
module tb_io_led_seg_ctrl;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        led_ctrl = 1'b0;
    logic [31:0] io_addr = 32'h0;
    logic [31:0] io_wdata = 32'h0;
    logic [15:0] led;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    io_led_seg_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .led_ctrl (led_ctrl),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .led      (led),
        .seg_an   (seg_an),
        .seg_cat  (seg_cat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: register contents and edges elapsed since reset release.
    int          m_ecnt;
    logic [15:0] m_led;
    logic [31:0] m_seg;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_cat(input logic [31:0] s, input int d);
        logic [31:0] upper;
        upper = s >> (4 * d);
`ifdef SEG_BLANK_EN
        if (d > 0 && upper == 32'd0) return 8'hFF;
`endif
        return hex_tab[upper[3:0]];
    endfunction

    // Drive one cycle of inputs, advance one edge, and compare all outputs to the model.
    task automatic cycle(input logic c, input logic [31:0] a, input logic [31:0] d);
        int         ip;
        logic [7:0] ea;
        logic [7:0] ec;
        led_ctrl = c;
        io_addr  = a;
        io_wdata = d;
        @(posedge clk);
        ip = (m_ecnt / SCAN_DIV) % 8;
        ea = ~(8'd1 << ip);
        ec = exp_cat(m_seg, ip);
        if (c && a[3:0] == 4'h0) m_led = d[15:0];
        if (c && a[3:0] == 4'h4) m_seg = d;
        m_ecnt++;
        #1;
        chk("led", {16'h0, led}, {16'h0, m_led});
        chk("seg_an", {24'h0, seg_an}, {24'h0, ea});
        chk("seg_cat", {24'h0, seg_cat}, {24'h0, ec});
        led_ctrl = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_led"}, {16'h0, led}, 32'h0);
        chk({tag, "_an"}, {24'h0, seg_an}, 32'hFE);
        chk({tag, "_cat"}, {24'h0, seg_cat}, 32'hC0);
    endtask

    // Assert reset mid-cycle with a write pending; the write must be lost.
    task automatic mid_reset();
        led_ctrl = 1'b1;
        io_addr  = 32'h0;
        io_wdata = 32'h0000_FFFF;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_imm");
        @(posedge clk);
        #1 check_reset_outputs("rst_hold");
        led_ctrl = 1'b0;
        #1 rst_n = 1'b1;
        m_ecnt = 0;
        m_led  = 16'h0;
        m_seg  = 32'h0;
    endtask

    initial begin
        int          sel;
        logic        c;
        logic [31:0] a;
        m_ecnt = 0;
        m_led  = 16'h0;
        m_seg  = 32'h0;

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        idle(5 + 8 * SCAN_DIV);

        cycle(1'b1, 32'h0, 32'hDEAD_A5C3);
        chk("led_a5c3", {16'h0, led}, 32'h0000_A5C3);

        cycle(1'b1, 32'h4, 32'h0123_89AF);
        idle(9 * SCAN_DIV);

        cycle(1'b1, 32'h8, 32'h1111_2222);
        cycle(1'b1, 32'hC, 32'h3333_4444);
        cycle(1'b0, 32'h0, 32'h5555_6666);
        cycle(1'b0, 32'h4, 32'h7777_8888);
        idle(2 * SCAN_DIV);

        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < SCAN_DIV && (m_ecnt % SCAN_DIV) != SCAN_DIV - 1; w++)
                cycle(1'b0, 32'h0, 32'h0);
            cycle(1'b1, 32'h4, $urandom);
            idle(SCAN_DIV + 2);
        end

        cycle(1'b1, 32'h4, 32'h0000_00F0);
        idle(9 * SCAN_DIV);
        cycle(1'b1, 32'h4, 32'h0000_0000);
        idle(9 * SCAN_DIV);

        mid_reset();
        idle(3 * SCAN_DIV + 2);

        for (int i = 0; i < 400; i++) begin
            c   = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 4);
            case (sel)
                0: a = 32'h0;
                1: a = 32'h4;
                2: a = 32'h8;
                3: a = 32'hC;
                default: a = $urandom;
            endcase
            if (c && $urandom_range(0, 3) == 0) a = {a[31:4], 4'h4} & 32'hFFFF_FFF4;
            cycle(c, a, ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_0F0F) : $urandom);
            if (i == 200) begin
                mid_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
